// File: rtl/branch_resolver.sv
// Fetch/resolve front end for a 2-bit branch predictor: requests predictions, queues them in order, trains on resolve.
// Optional saturating statistics counters are enabled by defining BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
`ifdef BRANCH_RESOLVER_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_fetch,
    output logic             fetch_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic             request,
    input  logic             prediction,
    output logic             result,
    output logic             taken,
    input  logic             br_resolve,
    input  logic             br_outcome,
    output logic             mispredict,
    output logic             resolve_err,
    output logic [PTR_W:0]   occupancy
`ifdef BRANCH_RESOLVER_STATS_EN
    , output logic [CNT_W-1:0] stat_resolved
    , output logic [CNT_W-1:0] stat_mispred
`endif
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, CAPT} state_t;

    state_t           state_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [DEPTH-1:0] entry_reg;
    logic [DEPTH-1:0] entry_we;

    logic request_reg;
    logic pred_valid_reg;
    logic pred_taken_reg;
    logic result_reg;
    logic taken_reg;
    logic mispredict_reg;
    logic resolve_err_reg;

    logic q_empty;
    logic q_full;
    logic head;
    logic pop;
    logic resolve_empty;
    logic mispred_now;
    logic accept;
    logic push;

    always_comb begin
        q_empty       = (count_reg == '0);
        q_full        = (count_reg == FULL_CNT);
        head          = entry_reg[rd_ptr_reg];
        pop           = br_resolve && !q_empty;
        resolve_empty = br_resolve && q_empty;
        mispred_now   = pop && (head != br_outcome);
        // A branch fetched on the same edge as a mispredict is wrong-path, so it is not accepted.
        accept        = (state_reg == IDLE) && br_fetch && !q_full && !mispred_now;
        push          = (state_reg == CAPT) && !mispred_now;
    end

    assign fetch_ready = (state_reg == IDLE) && !q_full && !mispred_now && !rst;
    assign request     = request_reg;
    assign pred_valid  = pred_valid_reg;
    assign pred_taken  = pred_taken_reg;
    assign result      = result_reg;
    assign taken       = taken_reg;
    assign mispredict  = mispredict_reg;
    assign resolve_err = resolve_err_reg;
    assign occupancy   = count_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Storage needs no reset: validity is defined by count_reg alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i]) begin
                entry_reg[i] <= prediction;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            request_reg     <= 1'b0;
            pred_valid_reg  <= 1'b0;
            pred_taken_reg  <= 1'b0;
            result_reg      <= 1'b0;
            taken_reg       <= 1'b0;
            mispredict_reg  <= 1'b0;
            resolve_err_reg <= 1'b0;
        end else begin
            request_reg     <= accept;
            pred_valid_reg  <= push;
            pred_taken_reg  <= push && prediction;
            result_reg      <= pop;
            taken_reg       <= pop && br_outcome;
            mispredict_reg  <= mispred_now;
            resolve_err_reg <= resolve_empty;

            case (state_reg)
                IDLE:    if (accept) state_reg <= REQ;
                REQ:     state_reg <= mispred_now ? IDLE : CAPT;
                CAPT:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            // A mispredict discards the head and everything younger, leaving the queue empty.
            if (mispred_now) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                wr_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                count_reg  <= '0;
            end else begin
                if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                count_reg <= count_reg + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
            end
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [CNT_W-1:0] stat_resolved_reg;
    logic [CNT_W-1:0] stat_mispred_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved_reg <= '0;
            stat_mispred_reg  <= '0;
        end else begin
            if (pop && (stat_resolved_reg != '1))
                stat_resolved_reg <= stat_resolved_reg + CNT_W'(1);
            if (mispred_now && (stat_mispred_reg != '1))
                stat_mispred_reg <= stat_mispred_reg + CNT_W'(1);
        end
    end

    assign stat_resolved = stat_resolved_reg;
    assign stat_mispred  = stat_mispred_reg;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: predictions queued at fetch, popped when pred_valid or a resolve appears.
module tb_branch_resolver;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic br_fetch = 1'b0;
    logic fetch_ready;
    logic pred_valid;
    logic pred_taken;
    logic request;
    logic prediction = 1'b0;
    logic result;
    logic taken;
    logic br_resolve = 1'b0;
    logic br_outcome = 1'b0;
    logic mispredict;
    logic resolve_err;
    logic [PTR_W:0] occupancy;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [1:0] stat_resolved;
    logic [1:0] stat_mispred;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit exp_q[$];    // predictions expected on pred_valid, in fetch order
    bit model_q[$];  // predictions the DUT should currently hold

    branch_resolver #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
`ifdef BRANCH_RESOLVER_STATS_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .br_fetch(br_fetch),
        .fetch_ready(fetch_ready),
        .pred_valid(pred_valid),
        .pred_taken(pred_taken),
        .request(request),
        .prediction(prediction),
        .result(result),
        .taken(taken),
        .br_resolve(br_resolve),
        .br_outcome(br_outcome),
        .mispredict(mispredict),
        .resolve_err(resolve_err),
        .occupancy(occupancy)
`ifdef BRANCH_RESOLVER_STATS_EN
        , .stat_resolved(stat_resolved)
        , .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    // Drive one branch fetch and sample the outputs two edges after acceptance.
    task automatic fetch_cycle(input bit p, output logic pv, output logic pt);
        @(negedge clk);
        br_fetch = 1'b1;
        prediction = p;
        exp_q.push_back(p);
        @(negedge clk);
        br_fetch = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pv = pred_valid;
        pt = pred_taken;
        $display("fetch   pred=%0b -> pred_valid=%0b pred_taken=%0b occ=%0d", p, pv, pt, occupancy);
    endtask

    task automatic resolve_cycle(input bit o, output logic [3:0] rtme, output logic [PTR_W:0] occ);
        @(negedge clk);
        br_resolve = 1'b1;
        br_outcome = o;
        @(negedge clk);
        br_resolve = 1'b0;
        rtme = {result, taken, mispredict, resolve_err};
        occ = occupancy;
        $display("resolve outcome=%0b -> result/taken/mispredict/err=%b occ=%0d", o, rtme, occ);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({fetch_ready, pred_valid, pred_taken, request, result, taken, mispredict, resolve_err} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {fetch_ready, pred_valid, pred_taken, request, result, taken, mispredict, resolve_err});
        end
        vectors++;
        if (occupancy !== '0) begin miscompares++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (fetch_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: got %b expected 1", fetch_ready); end
        // Abort a request in flight.
        br_fetch = 1'b1;
        prediction = 1'b1;
        @(negedge clk);
        br_fetch = 1'b0;
        vectors++;
        if (request !== 1'b1) begin miscompares++; $display("FAIL req_before_rst: got %b expected 1", request); end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (request !== 1'b0) begin miscompares++; $display("FAIL req_async_rst: got %b expected 0", request); end
        vectors++;
        if (occupancy !== '0) begin miscompares++; $display("FAIL occ_async_rst: got %0d expected 0", occupancy); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (pred_valid !== 1'b0) begin miscompares++; $display("FAIL no_pv_after_rst: got %b expected 0", pred_valid); end
        end
        vectors++;
        if (fetch_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_abort: got %b expected 1", fetch_ready); end
    endtask

    task automatic test_single();
        bit e;
        bit h;
        @(negedge clk);
        br_fetch = 1'b1;
        prediction = 1'b1;
        exp_q.push_back(1'b1);
        @(negedge clk);
        br_fetch = 1'b0;
        vectors++;
        if ({request, fetch_ready} !== 2'b10) begin miscompares++; $display("FAIL single_req: got %b expected 10", {request, fetch_ready}); end
        @(negedge clk);
        vectors++;
        if ({request, pred_valid} !== 2'b00) begin miscompares++; $display("FAIL single_capt: got %b expected 00", {request, pred_valid}); end
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if ({pred_valid, pred_taken} !== {1'b1, e}) begin
            miscompares++; $display("FAIL single_pred: got %b expected %b", {pred_valid, pred_taken}, {1'b1, e});
        end
        model_q.push_back(e);
        vectors++;
        if (occupancy !== 3'd1) begin miscompares++; $display("FAIL single_occ1: got %0d expected 1", occupancy); end
        br_resolve = 1'b1;
        br_outcome = 1'b1;
        @(negedge clk);
        br_resolve = 1'b0;
        h = model_q.pop_front();
        vectors++;
        if ({result, taken, mispredict, resolve_err} !== {1'b1, 1'b1, h != 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL single_resolve: got %b expected %b", {result, taken, mispredict, resolve_err}, {1'b1, 1'b1, h != 1'b1, 1'b0});
        end
        vectors++;
        if (occupancy !== 3'd0) begin miscompares++; $display("FAIL single_occ0: got %0d expected 0", occupancy); end
    endtask

    task automatic test_fill();
        bit preds[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        bit outs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic pv, pt;
        logic [3:0] rtme;
        logic [PTR_W:0] occ;
        bit e, h;
        for (int i = 0; i < 4; i++) begin
            fetch_cycle(preds[i], pv, pt);
            e = exp_q.pop_front();
            model_q.push_back(e);
            vectors++;
            if ({pv, pt} !== {1'b1, e}) begin miscompares++; $display("FAIL fill_pred%0d: got %b expected %b", i, {pv, pt}, {1'b1, e}); end
        end
        vectors++;
        if ({fetch_ready, occupancy} !== {1'b0, 3'd4}) begin
            miscompares++; $display("FAIL fill_full: got ready=%b occ=%0d expected ready=0 occ=4", fetch_ready, occupancy);
        end
        br_fetch = 1'b1;
        prediction = 1'b0;
        @(negedge clk);
        @(negedge clk);
        br_fetch = 1'b0;
        vectors++;
        if ({request, occupancy} !== {1'b0, 3'd4}) begin
            miscompares++; $display("FAIL fill_ignored: got req=%b occ=%0d expected req=0 occ=4", request, occupancy);
        end
        for (int i = 0; i < 4; i++) begin
            resolve_cycle(outs[i], rtme, occ);
            h = model_q.pop_front();
            vectors++;
            if (rtme !== {1'b1, outs[i], h != outs[i], 1'b0} || occ !== (PTR_W + 1)'(model_q.size())) begin
                miscompares++;
                $display("FAIL fill_resolve%0d: got %b occ=%0d expected %b occ=%0d", i, rtme, occ,
                         {1'b1, outs[i], h != outs[i], 1'b0}, model_q.size());
            end
        end
    endtask

    task automatic test_flush();
        logic pv, pt;
        logic [3:0] rtme;
        logic [PTR_W:0] occ;
        bit e, h;
        for (int i = 0; i < 3; i++) begin
            fetch_cycle(1'b0, pv, pt);
            e = exp_q.pop_front();
            model_q.push_back(e);
            vectors++;
            if ({pv, pt} !== {1'b1, e}) begin miscompares++; $display("FAIL flush_pred%0d: got %b expected %b", i, {pv, pt}, {1'b1, e}); end
        end
        resolve_cycle(1'b1, rtme, occ);
        h = model_q.pop_front();
        if (h != 1'b1) model_q.delete();
        vectors++;
        if (rtme !== {1'b1, 1'b1, h != 1'b1, 1'b0} || occ !== 3'd0) begin
            miscompares++; $display("FAIL flush_mispredict: got %b occ=%0d expected %b occ=0", rtme, occ, {1'b1, 1'b1, h != 1'b1, 1'b0});
        end
        resolve_cycle(1'b0, rtme, occ);
        vectors++;
        if (rtme !== 4'b0001 || occ !== 3'd0) begin
            miscompares++; $display("FAIL flush_empty_resolve: got %b occ=%0d expected 0001 occ=0", rtme, occ);
        end
    endtask

    task automatic test_back_to_back();
        logic pv, pt;
        logic [3:0] rtme;
        logic [PTR_W:0] occ;
        bit e, h;
        // Capture completes on the same edge as a mispredicted resolve.
        fetch_cycle(1'b0, pv, pt);
        e = exp_q.pop_front();
        model_q.push_back(e);
        @(negedge clk);
        br_fetch = 1'b1;
        prediction = 1'b1;
        @(negedge clk);
        br_fetch = 1'b0;
        @(negedge clk);
        br_resolve = 1'b1;
        br_outcome = 1'b1;
        @(negedge clk);
        br_resolve = 1'b0;
        h = model_q.pop_front();
        model_q.delete();
        vectors++;
        if ({pred_valid, result, mispredict, occupancy} !== {1'b0, 1'b1, h != 1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL b2b_mispredict: got pv=%b res=%b mis=%b occ=%0d expected pv=0 res=1 mis=%b occ=0",
                     pred_valid, result, mispredict, occupancy, h != 1'b1);
        end
        @(negedge clk);
        vectors++;
        if ({pred_valid, fetch_ready} !== 2'b01) begin miscompares++; $display("FAIL b2b_no_late_pv: got %b expected 01", {pred_valid, fetch_ready}); end
        // Same timing with a correct prediction: push and pop together.
        fetch_cycle(1'b1, pv, pt);
        e = exp_q.pop_front();
        model_q.push_back(e);
        @(negedge clk);
        br_fetch = 1'b1;
        prediction = 1'b0;
        exp_q.push_back(1'b0);
        @(negedge clk);
        br_fetch = 1'b0;
        @(negedge clk);
        br_resolve = 1'b1;
        br_outcome = 1'b1;
        @(negedge clk);
        br_resolve = 1'b0;
        h = model_q.pop_front();
        e = exp_q.pop_front();
        model_q.push_back(e);
        vectors++;
        if ({pred_valid, pred_taken, result, mispredict, occupancy} !== {1'b1, e, 1'b1, h != 1'b1, 3'd1}) begin
            miscompares++;
            $display("FAIL b2b_correct: got pv=%b pt=%b res=%b mis=%b occ=%0d expected pv=1 pt=%b res=1 mis=%b occ=1",
                     pred_valid, pred_taken, result, mispredict, occupancy, e, h != 1'b1);
        end
        resolve_cycle(1'b0, rtme, occ);
        h = model_q.pop_front();
        vectors++;
        if (rtme !== {1'b1, 1'b0, h != 1'b0, 1'b0} || occ !== 3'd0) begin
            miscompares++; $display("FAIL b2b_drain: got %b occ=%0d expected %b occ=0", rtme, occ, {1'b1, 1'b0, h != 1'b0, 1'b0});
        end
    endtask

`ifdef BRANCH_RESOLVER_STATS_EN
    task automatic test_stats();
        logic pv, pt;
        logic [3:0] rtme;
        logic [PTR_W:0] occ;
        int n_res = 0;
        int n_mis = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_q.delete();
        for (int i = 0; i < 5; i++) begin
            fetch_cycle(1'b0, pv, pt);
            void'(exp_q.pop_front());
            resolve_cycle((i == 0) ? 1'b0 : 1'b1, rtme, occ);
            n_res++;
            if (i != 0) n_mis++;
            if (i == 1) begin
                vectors++;
                if ({stat_resolved, stat_mispred} !== {2'(n_res), 2'(n_mis)}) begin
                    miscompares++; $display("FAIL stats_mid: got %0d/%0d expected %0d/%0d", stat_resolved, stat_mispred, n_res, n_mis);
                end
            end
        end
        vectors++;
        if ({stat_resolved, stat_mispred} !== {2'd3, 2'd3}) begin
            miscompares++; $display("FAIL stats_saturate: got %0d/%0d expected 3/3", stat_resolved, stat_mispred);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_flush();
        test_back_to_back();
`ifdef BRANCH_RESOLVER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
